// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind a valid/ready request/response pair.
// Each access waits a fixed number of cycles, commits, then holds its response until it is taken.
module data_mem_responder #(
    parameter int DM_ADDRESS  = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [3:0]            req_be,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err
);

    // Handshakes: a request transfers on a rising edge with req_valid && req_ready;
    // a response transfers on a rising edge with rsp_valid && rsp_ready. Once rsp_valid
    // rises, rsp_rdata/rsp_err stay constant until that transfer.

    localparam int          IDX_W     = DM_ADDRESS - 2;
    localparam int          DEPTH     = 1 << IDX_W;
    localparam bit          ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [3:0]  CNT_LOAD  = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                started_q;
    logic                we_q;
    logic [IDX_W-1:0]    idx_q;
    logic [3:0]          be_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                accept;
    logic                commit;
    logic                c_we;
    logic [IDX_W-1:0]    c_idx;
    logic [3:0]          c_be;
    logic [DATA_W-1:0]   c_wdata;
    logic                c_legal;
    logic                mem_we;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^req_addr[1:0];

    function automatic logic be_legal(input logic [3:0] be);
        case (be)
            4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: be_legal = 1'b1;
            default:                   be_legal = 1'b0;
        endcase
    endfunction

    assign req_ready = (state_q == IDLE) && started_q;
    assign accept    = req_valid && req_ready;

    // With no wait states the access commits on the accept edge straight from the inputs.
    assign c_we    = ZERO_WAIT ? req_we                    : we_q;
    assign c_idx   = ZERO_WAIT ? req_addr[DM_ADDRESS-1:2]  : idx_q;
    assign c_be    = ZERO_WAIT ? req_be                    : be_q;
    assign c_wdata = ZERO_WAIT ? req_wdata                 : wdata_q;
    assign c_legal = be_legal(c_be);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        commit      = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (ZERO_WAIT) begin
                        commit  = 1'b1;
                        state_d = RESP;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                // First RESP cycle raises rsp_valid; rsp_ready only counts once it is up.
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (commit) begin
            err_d   = !c_legal;
            rdata_d = (!c_we && c_legal) ? mem[c_idx] : '0;
        end
    end

    assign mem_we = commit && c_we && c_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            started_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            started_q   <= 1'b1;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            idx_q   <= '0;
            be_q    <= 4'd0;
            wdata_q <= '0;
        end else if (accept) begin
            we_q    <= req_we;
            idx_q   <= req_addr[DM_ADDRESS-1:2];
            be_q    <= req_be;
            wdata_q <= req_wdata;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (c_be[i]) begin
                    mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a word-array reference model.
module tb_data_mem_responder;

    localparam int DM_ADDRESS  = 9;
    localparam int DATA_W      = 32;
    localparam int WAIT_CYCLES = 2;
    localparam int WORDS       = 1 << (DM_ADDRESS - 2);

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  req_valid = 1'b0;
    logic                  req_ready;
    logic                  req_we = 1'b0;
    logic [DM_ADDRESS-1:0] req_addr = '0;
    logic [3:0]            req_be = 4'd0;
    logic [DATA_W-1:0]     req_wdata = '0;
    logic                  rsp_valid;
    logic                  rsp_ready = 1'b0;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    int checks = 0;
    int failures = 0;

    logic [31:0] model_mem [WORDS];
    logic [32:0] exp_q [$];

    data_mem_responder #(
        .DM_ADDRESS (DM_ADDRESS),
        .DATA_W     (DATA_W),
        .WAIT_CYCLES(WAIT_CYCLES)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_be   (req_be),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit legal_be(input logic [3:0] be);
        return be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
    endfunction

    // Model: compute the response and apply any write, in request order.
    function automatic logic [32:0] model_access(input logic we, input logic [8:0] addr,
                                                 input logic [3:0] be, input logic [31:0] wdata);
        int idx;
        logic [31:0] word;
        idx = int'(addr) / 4;
        if (!legal_be(be)) return {1'b1, 32'h0};
        if (!we) return {1'b0, model_mem[idx]};
        word = model_mem[idx];
        for (int b = 0; b < 4; b++)
            if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
        model_mem[idx] = word;
        return {1'b0, 32'h0};
    endfunction

    // Drive a request and return at the negedge after it was accepted.
    task automatic send(input logic we, input logic [8:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, output bit ok);
        int tries;
        ok = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_be    = be;
        req_wdata = wdata;
        tries = 0;
        while (!req_ready && tries < 50) begin
            @(negedge clk);
            tries++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = 9'($urandom);
        req_be    = 4'($urandom);
        req_wdata = $urandom;
        ok = 1'b1;
    endtask

    task automatic txn(input logic we, input logic [8:0] addr, input logic [3:0] be,
                       input logic [31:0] wdata, input int hold,
                       output logic [31:0] got_rdata, output logic got_err);
        bit ok;
        int lat;
        logic [32:0] exp;
        got_rdata = '0;
        got_err   = 1'b0;
        exp_q.push_back(model_access(we, addr, be, wdata));
        send(we, addr, be, wdata, ok);
        if (!ok) begin
            void'(exp_q.pop_front());
            return;
        end
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!rsp_valid && lat < 40);
        check("latency", 32'(lat), 32'(WAIT_CYCLES + 1));
        exp = exp_q.pop_front();
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            check("hold_rdata", rsp_rdata, exp[31:0]);
            check("hold_req_ready", 32'(req_ready), 32'd0);
        end
        got_rdata = rsp_rdata;
        got_err   = rsp_err;
        check("rsp_rdata", rsp_rdata, exp[31:0]);
        check("rsp_err", 32'(rsp_err), 32'(exp[32]));
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("valid_after_hs", 32'(rsp_valid), 32'd0);
        check("ready_after_hs", 32'(req_ready), 32'd1);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        bit          ok;
        int          n;

        // reset
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_first_edge", 32'(req_ready), 32'd1);

        for (int w = 0; w < WORDS; w++)
            txn(1'b1, 9'(w * 4), 4'b1111, $urandom, 0, rd, er);

        // Directed: full word, byte merge, illegal be, backpressure
        txn(1'b1, 9'h010, 4'b1111, 32'hDEADBEEF, 0, rd, er);
        txn(1'b0, 9'h010, 4'b0001, 32'h0, 0, rd, er);
        check("word_read", rd, 32'hDEADBEEF);
        txn(1'b1, 9'h010, 4'b0100, 32'h00AA0000, 0, rd, er);
        txn(1'b0, 9'h010, 4'b1111, 32'h0, 0, rd, er);
        check("byte_merge", rd, 32'hDEAABEEF);
        txn(1'b1, 9'h010, 4'b0101, 32'hFFFFFFFF, 0, rd, er);
        check("illegal_err", 32'(er), 32'd1);
        check("illegal_rdata", rd, 32'd0);
        txn(1'b0, 9'h010, 4'b0000, 32'h0, 0, rd, er);
        check("illegal_read_err", 32'(er), 32'd1);
        txn(1'b0, 9'h013, 4'b1000, 32'h0, 5, rd, er);
        check("after_illegal", rd, 32'hDEAABEEF);

        // Reset during WAIT discards the write
        txn(1'b1, 9'h020, 4'b1111, 32'hCAFEF00D, 0, rd, er);
        send(1'b1, 9'h020, 4'b1111, 32'h12345678, ok);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_wait");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", 32'(req_ready), 32'd1);
        txn(1'b0, 9'h020, 4'b1111, 32'h0, 0, rd, er);
        check("rst_wait_old", rd, 32'hCAFEF00D);
        txn(1'b1, 9'h1FC, 4'b1111, 32'hA5A5_5A5A, 0, rd, er);
        txn(1'b0, 9'h1FF, 4'b0011, 32'h0, 0, rd, er);
        check("top_word", rd, 32'hA5A55A5A);

        // Reset during RESP drops the response
        send(1'b0, 9'h1FC, 4'b1111, 32'h0, ok);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("resp_seen", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_resp");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst2", 32'(req_ready), 32'd1);

        // Random traffic
        for (int t = 0; t < 300; t++) begin
            txn(1'($urandom), 9'($urandom_range(0, 511)), 4'($urandom_range(0, 15)),
                $urandom, $urandom_range(0, 3), rd, er);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
